// File: rtl/split_case_pkg.sv
// Shared types and constants for the split-case adjust scheduler.
// The operation select enum and the add/subtract adjust amounts live here.
package split_case_pkg;

  typedef enum logic [1:0] {
    SEL_ADD  = 2'b00,
    SEL_SUB  = 2'b01,
    SEL_PASS = 2'b10
  } sel_t;

  localparam logic [7:0] ADJ_A = 8'd5;
  localparam logic [7:0] ADJ_B = 8'd6;

endpackage

// File: rtl/split_case_sched_if.sv
// Request and result handshake bundle for split_case_sched.
// The master side is the requesters plus the result consumer; the slave side is the scheduler.
interface split_case_sched_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [1:0] req0_sel;

  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [1:0] req1_sel;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       out_id;

  modport master (
    output req0_valid, req0_data, req0_sel, input req0_ready,
    output req1_valid, req1_data, req1_sel, input req1_ready,
    input  out_valid, out_a, out_b, out_id, output out_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_sel, output req0_ready,
    input  req1_valid, req1_data, req1_sel, output req1_ready,
    output out_valid, out_a, out_b, out_id, input out_ready
  );
endinterface

// File: rtl/split_case_adjust.sv
// Combinational split-case adjust datapath: two modulo-256 results from one byte.
// Select 2'b11 is not an enum member and falls through to pass-through.
module split_case_adjust
  import split_case_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] sel,
  output logic [7:0] a,
  output logic [7:0] b
);

  always_comb begin
    a = data;
    b = data;
    case (sel_t'(sel))
      SEL_ADD: begin
        a = data + ADJ_A;
        b = data + ADJ_B;
      end
      SEL_SUB: begin
        a = data - ADJ_A;
        b = data - ADJ_B;
      end
      default: begin
        a = data;
        b = data;
      end
    endcase
  end

endmodule

// File: rtl/split_case_sched.sv
// Two-requester round-robin scheduler feeding one adjust datapath into a
// one-entry result slot, with saturating per-requester completion counters.
module split_case_sched
  import split_case_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  split_case_sched_if.slave bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             out_valid_reg;
  logic [7:0]       out_a_reg;
  logic [7:0]       out_b_reg;
  logic             out_id_reg;
  logic             last_reg;
  logic [CNT_W-1:0] cnt_reg [2];

  logic       slot_free;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       drain;
  logic [7:0] mux_data;
  logic [1:0] mux_sel;
  logic [7:0] adj_a;
  logic [7:0] adj_b;

  assign slot_free = !out_valid_reg || bus.out_ready;
  assign drain     = out_valid_reg && bus.out_ready;

  // On contention the requester that did not win last time is served.
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_reg);
  assign grant0 = bus.req0_valid && !grant1;

  assign bus.req0_ready = grant0 && slot_free && !rst;
  assign bus.req1_ready = grant1 && slot_free && !rst;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign mux_data = grant1 ? bus.req1_data : bus.req0_data;
  assign mux_sel  = grant1 ? bus.req1_sel  : bus.req0_sel;

  split_case_adjust u_adjust (
    .data (mux_data),
    .sel  (mux_sel),
    .a    (adj_a),
    .b    (adj_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= 8'd0;
      out_b_reg     <= 8'd0;
      out_id_reg    <= 1'b0;
      last_reg      <= 1'b1;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_a_reg     <= adj_a;
      out_b_reg     <= adj_b;
      out_id_reg    <= grant1;
      last_reg      <= grant1;
    end else if (drain) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Counters credit the id held in the slot as it leaves, even when refilled on the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (drain && (out_id_reg == 1'(gi)) && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.out_valid = out_valid_reg;
  assign bus.out_a     = out_a_reg;
  assign bus.out_b     = out_b_reg;
  assign bus.out_id    = out_id_reg;
  assign cnt0          = cnt_reg[0];
  assign cnt1          = cnt_reg[1];

endmodule

// File: tb/tb_split_case_sched.sv
// Directed bench for split_case_sched: an 8-bit-counter instance plus a 2-bit-counter
// instance that mirrors the same stimulus to exercise counter saturation.
module tb_split_case_sched;

  logic       clk;
  logic       rst;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt0_s;
  logic [1:0] cnt1_s;

  int vectors;
  int miscompares;

  split_case_sched_if bus ();
  split_case_sched_if bus_s ();

  split_case_sched #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );

  split_case_sched #(.CNT_W(2)) dut_s (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_s.slave),
    .cnt0 (cnt0_s),
    .cnt1 (cnt1_s)
  );

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_data  = bus.req0_data;
  assign bus_s.req0_sel   = bus.req0_sel;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_data  = bus.req1_data;
  assign bus_s.req1_sel   = bus.req1_sel;
  assign bus_s.out_ready  = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic id);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".a"}, 32'(bus.out_a), 32'(a));
    check({tag, ".b"}, 32'(bus.out_b), 32'(b));
    check({tag, ".id"}, 32'(bus.out_id), 32'(id));
  endtask

  task automatic set_req(input int n, input logic v, input logic [7:0] d, input logic [1:0] s);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_sel = s;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_sel = s;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_req(0, 1'b0, 8'h00, 2'b00);
    set_req(1, 1'b0, 8'h00, 2'b00);
    step();
    step();
    rst = 1'b0;
    #1;

    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.a", 32'(bus.out_a), 32'd0);
    check("rst.b", 32'(bus.out_b), 32'd0);
    check("rst.id", 32'(bus.out_id), 32'd0);
    check("rst.cnt0", 32'(cnt0), 32'd0);
    check("rst.cnt1", 32'(cnt1), 32'd0);

    // First transaction: 0x10 add
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 8'h10, 2'b00);
    #1;
    check("t1.ready0", 32'(bus.req0_ready), 32'd1);
    check("t1.ready1", 32'(bus.req1_ready), 32'd0);
    step();
    set_req(0, 1'b0, 8'h00, 2'b00);
    check_out("t1", 8'h15, 8'h16, 1'b0);
    check("t1.cnt0_before", 32'(cnt0), 32'd0);
    step();
    check("t1.drained", 32'(bus.out_valid), 32'd0);
    check("t1.cnt0", 32'(cnt0), 32'd1);
    check("t1.hold_a", 32'(bus.out_a), 32'h15);

    // Wrap-around through requester 1
    set_req(1, 1'b1, 8'hFE, 2'b00);
    step();
    check_out("wrap_add", 8'h03, 8'h04, 1'b1);
    set_req(1, 1'b1, 8'h03, 2'b01);
    step();
    check_out("wrap_sub", 8'hFE, 8'hFD, 1'b1);
    set_req(1, 1'b1, 8'h7C, 2'b11);
    step();
    check_out("pass11", 8'h7C, 8'h7C, 1'b1);
    set_req(1, 1'b0, 8'h00, 2'b00);
    step();
    check("wrap.cnt1", 32'(cnt1), 32'd3);
    check("wrap.cnt1_sat", 32'(cnt1_s), 32'd3);

    // Sustained contention alternates strictly, starting with requester 0
    set_req(0, 1'b1, 8'h20, 2'b10);
    set_req(1, 1'b1, 8'h40, 2'b10);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("alt%0d.id", i), 32'(bus.out_id), 32'(i % 2));
      check($sformatf("alt%0d.a", i), 32'(bus.out_a), (i % 2 == 1) ? 32'h40 : 32'h20);
    end
    set_req(0, 1'b0, 8'h00, 2'b00);
    set_req(1, 1'b0, 8'h00, 2'b00);
    step();
    check("alt.cnt0", 32'(cnt0), 32'd4);
    check("alt.cnt1", 32'(cnt1), 32'd6);

    // Backpressure with both requesters pending
    set_req(0, 1'b1, 8'h30, 2'b00);
    step();
    check_out("bp.load", 8'h35, 8'h36, 1'b0);
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 8'h50, 2'b01);
    set_req(1, 1'b1, 8'h60, 2'b00);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp%0d.ready0", i), 32'(bus.req0_ready), 32'd0);
      check($sformatf("bp%0d.ready1", i), 32'(bus.req1_ready), 32'd0);
      check_out($sformatf("bp%0d", i), 8'h35, 8'h36, 1'b0);
      check($sformatf("bp%0d.cnt0", i), 32'(cnt0), 32'd4);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.rel.ready1", 32'(bus.req1_ready), 32'd1);
    check("bp.rel.ready0", 32'(bus.req0_ready), 32'd0);
    step();
    check_out("bp.refill", 8'h65, 8'h66, 1'b1);
    check("bp.cnt0", 32'(cnt0), 32'd5);
    set_req(0, 1'b0, 8'h00, 2'b00);
    set_req(1, 1'b0, 8'h00, 2'b00);
    step();
    check("bp.cnt1", 32'(cnt1), 32'd7);

    // Reset mid-operation with slot full and both requests pending
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 8'h11, 2'b00);
    step();
    check_out("pre_rst", 8'h16, 8'h17, 1'b0);
    set_req(1, 1'b1, 8'h22, 2'b00);
    rst = 1'b1;
    #1;
    check("rst2.ready0", 32'(bus.req0_ready), 32'd0);
    check("rst2.ready1", 32'(bus.req1_ready), 32'd0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst2.valid", 32'(bus.out_valid), 32'd0);
    check("rst2.cnt0", 32'(cnt0), 32'd0);
    check("rst2.cnt1", 32'(cnt1), 32'd0);
    check("rst2.cnt0_s", 32'(cnt0_s), 32'd0);
    check("rst2.grant0", 32'(bus.req0_ready), 32'd1);
    check("rst2.grant1", 32'(bus.req1_ready), 32'd0);
    step();
    check_out("rst2.first", 8'h16, 8'h17, 1'b0);

    // Saturation: only requester 0, drained every cycle
    set_req(1, 1'b0, 8'h00, 2'b00);
    set_req(0, 1'b1, 8'h00, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("sat%0d.cnt0_s", k), 32'(cnt0_s), (k < 3) ? 32'(k) : 32'd3);
      check($sformatf("sat%0d.cnt0", k), 32'(cnt0), 32'(k));
    end
    set_req(0, 1'b0, 8'h00, 2'b00);
    step();
    check("sat.final_cnt0", 32'(cnt0), 32'd6);
    check("sat.final_cnt0_s", 32'(cnt0_s), 32'd3);
    check("sat.final_valid", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/split_case_sched.md
# split_case_sched

Two-requester round-robin scheduler for the shared split-case adjust datapath. The datapath computes two 8-bit results from one data byte and a 2-bit operation select. The block arbitrates between two valid/ready request ports and issues at most one operation per cycle to the datapath. It registers the result pair together with the requester ID into a one-entry output slot with valid/ready backpressure, and keeps a saturating per-requester completion count.

## Interface
Parameters:
- CNT_W, 8, width of each per-requester completion counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_data  in  8  requester 0 operand.
- req0_sel  in  2  requester 0 operation select.
- req1_valid, req1_ready, req1_data, req1_sel: same as requester 0, for requester 1.
- out_valid  out  1  result slot holds a result.
- out_ready  in  1  consumer takes the result.
- out_a  out  8  primary result.
- out_b  out  8  secondary result.
- out_id  out  1  requester that issued the result.
- cnt0  out  CNT_W  results delivered for requester 0, saturating.
- cnt1  out  CNT_W  results delivered for requester 1, saturating.

## Operation
- Datapath arithmetic is modulo 256, with the carry/borrow discarded:
  - sel 00: a = data+5, b = data+6.
  - sel 01: a = data−5, b = data−6.
  - sel 10 and 11: a = b = data.
- The slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (drain and refill together).
- Grant is combinational and is given only when the slot is free:
  - Only one req valid: that requester is granted.
  - Both valid: the requester selected by the round-robin pointer `last` is granted. The grant goes to the requester that is not `last`.
  - reqN_ready = granted to N. reqN_ready may depend on reqN_valid. The arbiter never raises ready for a requester that is not valid.
- On accept, the slot loads a, b and id, and out_valid=1.
- When the slot drains with no new accept, out_valid=0. out_a, out_b and out_id hold their last values.
- `last` updates to the granted id on every accept. It is unchanged when nothing is accepted.
- Completion counting:
  - cntN increments when the slot drains (out_valid & out_ready) with out_id=N.
  - cntN saturates at all-ones and never wraps.
- Requesters must hold data and sel stable while valid and not ready. The block does not capture operands before accept.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_id=0, cnt0=0, cnt1=0, `last`=1. With `last`=1, requester 0 wins the first contention after reset.
- Latency: result visible on out_* 1 cycle after the accepting edge.
- Throughput: one result per cycle while out_ready=1 and any request is valid.
- Backpressure (out_valid=1, out_ready=0):
  - Both reqN_ready=0.
  - The slot, `last` and the counters hold.
- Simultaneous drain and accept: the counter credits the old out_id and the slot loads the new result in the same edge.
- Reset asserted mid-operation: the slot is discarded and every register returns to its reset value at the next edge. Requests pending during rst see ready=0.
- Both requesters starve-free: under sustained dual requests the grants alternate strictly.

## Structure
- Package split_case_pkg:
  - Enum sel_t: SEL_ADD=2'b00, SEL_SUB=2'b01, SEL_PASS=2'b10. 2'b11 decodes as pass.
  - Localparams ADJ_A=5 and ADJ_B=6.
- Sub-module split_case_adjust: a purely combinational datapath with inputs data[7:0] and sel[1:0] and outputs a[7:0] and b[7:0]. It is instantiated once, fed by the grant mux.
- The scheduler holds the grant mux, the round-robin pointer, the output slot and the counters.

## Test plan
- After reset, req0 data=0x10 sel=00 with out_ready=1 → next cycle out_a=0x15, out_b=0x16, out_id=0; cnt0=1 one cycle later.
- Wrap-around:
  - req1 data=0xFE sel=00 → out_a=0x03, out_b=0x04.
  - Then data=0x03 sel=01 → out_a=0xFE, out_b=0xFD.
  - Then data=0x7C sel=11 → out_a=out_b=0x7C.
- Both requesters valid for 6 cycles with out_ready=1 → out_id sequence 0,1,0,1,0,1; cnt0=cnt1=3.
- Hold out_ready=0 for 4 cycles with a result in the slot → reqN_ready=0 and out_* stable throughout. Raising out_ready → drain and a new accept occur on the same edge, with no bubble.
- CNT_W=2, 5 requester-0 results drained → cnt0 sequence 1,2,3,3,3.
- Assert rst for 1 cycle while out_valid=1 and both requests pending → out_valid=0 and counters=0 next cycle. The first post-reset contention grants requester 0.
